rack_jtag_engine: RTL and testbench
===================================

// Module: rack_jtag_engine
// PURPOSE
//  Wishbone-controlled multi-channel JTAG/shift-register engine.
//  Shifts 1..MAX_BITS bits per transaction on one selected module, with a runtime clock divider
//  and selectable bit order. Drives TCK/TDI/TMS and captures TDO, plus NGPIO general-purpose pins.
//  Sits on the rack-side Wishbone bus and drives the per-module JTAG and LE pins.
// PARAMETERS
//  NMOD      2   number of JTAG modules (1..8); MOD_BITS = (NMOD>1) ? $clog2(NMOD) : 1
//  NGPIO     1   number of GPIOs (1..8)
//  MAX_BITS  32  maximum bits per shift transaction (1..32)
// PORTS
//  wb_clk     in   1         sole clock
//  wb_rst_n   in   1         asynchronous, active-low reset
//  wb_cyc_i   in   1         WB cycle
//  wb_stb_i   in   1         WB strobe
//  wb_we_i    in   1         WB write enable
//  wb_adr_i   in   4         byte address; [3:2] selects the register
//  wb_sel_i   in   4         byte lane enables
//  wb_dat_i   in   32        write data
//  wb_dat_o   out  32        read data
//  wb_ack_o   out  1         acknowledge
//  sr_clk     out  NMOD      TCK per module
//  sr_do      out  NMOD      TDI per module
//  sr_aux_do  out  NMOD      TMS per module
//  sr_oe      out  NMOD      output enable per module (tristate control)
//  sr_di      in   NMOD      TDO per module
//  gpio_o     out  NGPIO     GPIO output value
//  gpio_oe    out  NGPIO     GPIO output enable
//  gpio_i     in   NGPIO     GPIO input
// BEHAVIOUR
//  Registers:
//   0x0 CTRL
//    [2:0] mod_sel; [4] mod_en; [5] msb_first
//    [15:8] div: each phase lasts div+1 cycles
//    [20:16] nbits-1, saturated at MAX_BITS-1
//    [31] busy (read-only)
//   0x4 GPIO: [7:0] out, [15:8] oe, [23:16] gpio_i (read-only)
//   0x8 TMS: TMS shift data
//   0xC TDI
//    Write: loads TDI and starts a sequence.
//    Read: returns the capture register, right-aligned, upper bits 0.
//  Byte lanes: writes honour wb_sel_i per byte lane.
//  WB handshake:
//   Reads, and writes while idle, get a 1-cycle ack: ack is asserted the cycle after cyc&stb&!ack.
//   Any write while busy is stalled: no ack, and the write is not applied until busy=0.
//   After busy clears it is applied and acked on the next cycle.
//   ack is never asserted for two consecutive cycles.
//  FSM states IDLE -> SHIFT -> FINISH -> IDLE.
//   The TDI write moves IDLE->SHIFT and sets busy on the ack cycle.
//   SHIFT: per bit, four phases, each lasting div+1 cycles:
//    P0: TCK low
//    P1: update TDI/TMS from the shift registers
//    P2: TCK high
//    P3: sample sr_di[mod_sel] into the capture register
//   After P3 of bit nbits-1 -> FINISH, which drives TCK low for one phase, then -> IDLE with busy=0.
//   Total busy time: (4*nbits+1)*(div+1) cycles.
//  Bit order:
//   LSB-first: drive bit 0 and shift right; the capture enters at bit nbits-1 and shifts right.
//   MSB-first: drive bit nbits-1 and shift left; the capture enters at bit 0.
//   Either way the result is right-aligned in [nbits-1:0].
//  Module outputs:
//   Only module mod_sel toggles, and only when mod_en=1.
//   All other modules hold clk/do/aux at 0 with sr_oe=0.
//   sr_oe[mod_sel] = mod_en.
//   mod_sel >= NMOD: no module is driven, the sequence timing is unchanged, and the capture is all 0.
//   Between sequences the selected TDI/TMS hold their last value and TCK stays low.
//  Reset (asynchronous, immediate, including mid-sequence):
//   All outputs are 0 (sr_*, gpio_o, gpio_oe, wb_ack_o, wb_dat_o).
//   All registers are 0: FSM IDLE, busy=0.
// TESTING
//  Reset:
//   Assert wb_rst_n=0 -> all outputs 0.
//   Read CTRL -> 0x00000000.
//  LSB-first loopback:
//   CTRL: nbits=8, div=0, mod_sel=1, mod_en=1. TMS=0x01. TDI=0xA5. sr_di[1] looped from sr_do[1].
//   -> 8 rising edges on sr_clk[1]; sr_aux_do[1] is 1 for the first bit only; sr_clk[0]=0 throughout.
//   -> busy for 33 cycles; read 0xC -> 0x000000A5.
//  MSB-first:
//   CTRL: msb_first=1, nbits=32, div=3, mod_sel=0. TDI=0x80000001, loopback.
//   -> first TDI bit is 1; busy for 516 cycles; capture 0x80000001.
//  Stall:
//   Write TDI=0x3 during a busy sequence -> no ack until busy falls.
//   -> then ack; a second sequence starts and shifts 0x3.
//  Mid-sequence reset:
//   Pulse wb_rst_n low mid-SHIFT -> sr_clk/do/oe drop to 0 without waiting for a clock edge.
//   -> after release: busy=0, and a TDI write runs a clean sequence.
//  GPIO:
//   Write 0x4 = 0x0101 -> gpio_o[0]=1, gpio_oe[0]=1.
//   gpio_i=1 -> read 0x4 has bit 16 set.
//   A write with wb_sel_i=4'b0010 changes only oe.

Source files
------------

// File: rtl/rack_jtag_engine.sv
// ============================================================================
// Module   : rack_jtag_engine
// Purpose  : Wishbone-controlled multi-channel JTAG / shift-register engine
// Revision : 1.0
// ============================================================================
`default_nettype none

module rack_jtag_engine #(
    parameter int NMOD     = 2,
    parameter int NGPIO    = 1,
    parameter int MAX_BITS = 32
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [3:0]       wb_adr_i,
    input  logic [3:0]       wb_sel_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic [NMOD-1:0]  sr_clk,
    output logic [NMOD-1:0]  sr_do,
    output logic [NMOD-1:0]  sr_aux_do,
    output logic [NMOD-1:0]  sr_oe,
    input  logic [NMOD-1:0]  sr_di,
    output logic [NGPIO-1:0] gpio_o,
    output logic [NGPIO-1:0] gpio_oe,
    input  logic [NGPIO-1:0] gpio_i
);

    localparam logic [4:0] C_NB_MAX = 5'(MAX_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ph_q, ph_d;
    logic [7:0]       div_cnt_q, div_cnt_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [2:0]       mod_sel_q, mod_sel_d;
    logic             mod_en_q, mod_en_d;
    logic             msb_q, msb_d;
    logic [7:0]       div_q, div_d;
    logic [4:0]       nbm1_q, nbm1_d;
    logic [NGPIO-1:0] gpo_q, gpo_d;
    logic [NGPIO-1:0] gpoe_q, gpoe_d;
    logic [31:0]      tms_q, tms_d;
    logic [31:0]      tdi_q, tdi_d;
    logic [31:0]      sh_tdi_q, sh_tdi_d;
    logic [31:0]      sh_tms_q, sh_tms_d;
    logic [31:0]      cap_q, cap_d;
    logic             clk_q, clk_d;
    logic             do_q, do_d;
    logic             aux_q, aux_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;

    logic        w_busy, w_req, w_accept, w_wr, w_tdo, w_phase_end;
    logic [31:0] w_ctrl_word, w_gpio_word, w_cur, w_rdata, w_wdata;
    logic        w_unused;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction

    assign w_unused    = ^wb_adr_i[1:0];
    assign w_busy      = (state_q != S_IDLE);
    assign w_req       = wb_cyc_i & wb_stb_i & ~ack_q;
    // Writes wait for the sequence to drain; reads are always served.
    assign w_accept    = w_req & (~wb_we_i | ~w_busy);
    assign w_wr        = w_accept & wb_we_i;
    assign w_phase_end = (div_cnt_q == div_q);

    assign w_ctrl_word = {w_busy, 10'd0, nbm1_q, div_q, 2'd0, msb_q, mod_en_q, 1'b0, mod_sel_q};

    always_comb begin
        w_gpio_word                 = '0;
        w_gpio_word[0 +: NGPIO]     = gpo_q;
        w_gpio_word[8 +: NGPIO]     = gpoe_q;
        w_gpio_word[16 +: NGPIO]    = gpio_i;
    end

    always_comb begin
        case (wb_adr_i[3:2])
            2'd0:    w_cur = w_ctrl_word;
            2'd1:    w_cur = w_gpio_word;
            2'd2:    w_cur = tms_q;
            default: w_cur = tdi_q;
        endcase
        w_rdata = (wb_adr_i[3:2] == 2'd3) ? cap_q : w_cur;
        w_wdata = f_merge(w_cur, wb_dat_i, wb_sel_i);
    end

    // Only the selected module sees activity; everything else is parked low.
    always_comb begin
        sr_clk    = '0;
        sr_do     = '0;
        sr_aux_do = '0;
        sr_oe     = '0;
        w_tdo     = 1'b0;
        for (int i = 0; i < NMOD; i++) begin
            if (int'(mod_sel_q) == i) begin
                sr_clk[i]    = mod_en_q & clk_q;
                sr_do[i]     = mod_en_q & do_q;
                sr_aux_do[i] = mod_en_q & aux_q;
                sr_oe[i]     = mod_en_q;
                w_tdo        = sr_di[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        mod_sel_d = mod_sel_q;
        mod_en_d  = mod_en_q;
        msb_d     = msb_q;
        div_d     = div_q;
        nbm1_d    = nbm1_q;
        gpo_d     = gpo_q;
        gpoe_d    = gpoe_q;
        tms_d     = tms_q;
        tdi_d     = tdi_q;
        sh_tdi_d  = sh_tdi_q;
        sh_tms_d  = sh_tms_q;
        cap_d     = cap_q;
        clk_d     = clk_q;
        do_d      = do_q;
        aux_d     = aux_q;
        ack_d     = w_accept;
        dat_d     = (w_accept & ~wb_we_i) ? w_rdata : dat_q;

        if (w_wr) begin
            case (wb_adr_i[3:2])
                2'd0: begin
                    mod_sel_d = w_wdata[2:0];
                    mod_en_d  = w_wdata[4];
                    msb_d     = w_wdata[5];
                    div_d     = w_wdata[15:8];
                    nbm1_d    = (w_wdata[20:16] > C_NB_MAX) ? C_NB_MAX : w_wdata[20:16];
                end
                2'd1: begin
                    gpo_d  = w_wdata[0 +: NGPIO];
                    gpoe_d = w_wdata[8 +: NGPIO];
                end
                2'd2: tms_d = w_wdata;
                default: begin
                    tdi_d     = w_wdata;
                    sh_tdi_d  = w_wdata;
                    sh_tms_d  = tms_q;
                    cap_d     = '0;
                    clk_d     = 1'b0;
                    ph_d      = 2'd0;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            endcase
        end

        case (state_q)
            S_SHIFT: begin
                if (!w_phase_end) begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end else begin
                    div_cnt_d = '0;
                    ph_d      = ph_q + 2'd1;
                    case (ph_q)
                        2'd0: begin
                            do_d  = msb_q ? sh_tdi_q[nbm1_q] : sh_tdi_q[0];
                            aux_d = msb_q ? sh_tms_q[nbm1_q] : sh_tms_q[0];
                            sh_tdi_d = msb_q ? {sh_tdi_q[30:0], 1'b0} : {1'b0, sh_tdi_q[31:1]};
                            sh_tms_d = msb_q ? {sh_tms_q[30:0], 1'b0} : {1'b0, sh_tms_q[31:1]};
                        end
                        2'd1: clk_d = 1'b1;
                        2'd2: ;
                        default: begin
                            if (msb_q) begin
                                cap_d = {cap_q[30:0], w_tdo};
                            end else begin
                                cap_d         = {1'b0, cap_q[31:1]};
                                cap_d[nbm1_q] = w_tdo;
                            end
                            clk_d = 1'b0;
                            if (bit_cnt_q == nbm1_q) state_d = S_FINISH;
                            else                     bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    endcase
                end
            end
            S_FINISH: begin
                if (w_phase_end) begin
                    div_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= S_IDLE;
            ph_q      <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            mod_sel_q <= '0;
            mod_en_q  <= 1'b0;
            msb_q     <= 1'b0;
            div_q     <= '0;
            nbm1_q    <= '0;
            gpo_q     <= '0;
            gpoe_q    <= '0;
            tms_q     <= '0;
            tdi_q     <= '0;
            sh_tdi_q  <= '0;
            sh_tms_q  <= '0;
            cap_q     <= '0;
            clk_q     <= 1'b0;
            do_q      <= 1'b0;
            aux_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            mod_sel_q <= mod_sel_d;
            mod_en_q  <= mod_en_d;
            msb_q     <= msb_d;
            div_q     <= div_d;
            nbm1_q    <= nbm1_d;
            gpo_q     <= gpo_d;
            gpoe_q    <= gpoe_d;
            tms_q     <= tms_d;
            tdi_q     <= tdi_d;
            sh_tdi_q  <= sh_tdi_d;
            sh_tms_q  <= sh_tms_d;
            cap_q     <= cap_d;
            clk_q     <= clk_d;
            do_q      <= do_d;
            aux_q     <= aux_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign gpio_o   = gpo_q;
    assign gpio_oe  = gpoe_q;

endmodule

`default_nettype wire

// File: tb/tb_rack_jtag_engine.sv
// ============================================================================
// Module   : tb_rack_jtag_engine
// Purpose  : Directed, table-driven bench for rack_jtag_engine
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rack_jtag_engine;

    localparam int NMOD  = 2;
    localparam int NGPIO = 1;

    logic             wb_clk = 1'b0;
    logic             wb_rst_n = 1'b1;
    logic             cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]       adr = '0, sel = '0;
    logic [31:0]      dat_i = '0;
    logic [31:0]      dat_o;
    logic             ack;
    logic [NMOD-1:0]  sr_clk, sr_do, sr_aux_do, sr_oe, sr_di;
    logic [NGPIO-1:0] gpio_o, gpio_oe;
    logic [NGPIO-1:0] gpio_i = '0;

    rack_jtag_engine #(.NMOD(NMOD), .NGPIO(NGPIO), .MAX_BITS(32)) dut (
        .wb_clk    (wb_clk),
        .wb_rst_n  (wb_rst_n),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_sel_i  (sel),
        .wb_dat_i  (dat_i),
        .wb_dat_o  (dat_o),
        .wb_ack_o  (ack),
        .sr_clk    (sr_clk),
        .sr_do     (sr_do),
        .sr_aux_do (sr_aux_do),
        .sr_oe     (sr_oe),
        .sr_di     (sr_di),
        .gpio_o    (gpio_o),
        .gpio_oe   (gpio_oe),
        .gpio_i    (gpio_i)
    );

    assign sr_di = sr_do;

    always #5 wb_clk = ~wb_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_cnt = 0;
    int clk0_edges = 0, clk1_edges = 0;
    int ack_double = 0;
    logic ack_prev = 1'b0;
    logic [31:0] hist0_tdi = '0, hist1_tdi = '0, hist1_tms = '0;

    always @(posedge wb_clk) cyc_cnt++;
    always @(negedge wb_clk) begin
        if (ack && ack_prev) ack_double++;
        ack_prev = ack;
    end
    always @(posedge sr_clk[0]) begin
        clk0_edges++;
        hist0_tdi = {hist0_tdi[30:0], sr_do[0]};
    end
    always @(posedge sr_clk[1]) begin
        clk1_edges++;
        hist1_tdi = {hist1_tdi[30:0], sr_do[1]};
        hist1_tms = {hist1_tms[30:0], sr_aux_do[1]};
    end

    typedef struct {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp_rd;
        logic        exp_go;
        logic        exp_oe;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output int t_ack);
        @(posedge wb_clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        t_ack = -1;
        for (int k = 0; k < 2000; k++) begin
            @(posedge wb_clk);
            #1;
            if (ack) begin
                t_ack = cyc_cnt;
                break;
            end
        end
        rd  = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (t_ack < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wb_ack_timeout: got no ack expected ack (adr 0x%h)", a);
        end
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int t;
        wb_xfer(1'b1, a, d, 4'hF, rd, t);
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] rd);
        int t;
        wb_xfer(1'b0, a, 32'h0, 4'hF, rd, t);
    endtask

    task automatic wait_idle();
        logic [31:0] rd;
        for (int k = 0; k < 400; k++) begin
            wb_read(4'h0, rd);
            if (!rd[31]) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL busy_timeout: got busy=1 expected busy=0");
    endtask

    // Starts a sequence, then issues a write that must stall; returns busy length.
    task automatic run_seq(input logic [31:0] tdi, input logic [31:0] tms_after, output int busy_cycles);
        logic [31:0] rd;
        int t0, t1;
        wb_xfer(1'b1, 4'hC, tdi, 4'hF, rd, t0);
        wb_xfer(1'b1, 4'h8, tms_after, 4'hF, rd, t1);
        busy_cycles = t1 - t0 - 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int b, e0, e1;

        vecs[0]  = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h00000000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'h0, 32'h001F0330, 4'hF, 32'h0,        1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h001F0330, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'h0, 32'hFFFFFFFF, 4'h1, 32'h0,        1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h001F0337, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'h0, 32'h0,        4'hF, 32'h0,        1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h00000000, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'h4, 32'h00000101, 4'hF, 32'h0,        1'b1, 1'b1};
        vecs[8]  = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h00010101, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 4'h4, 32'h00000000, 4'h2, 32'h0,        1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h00010001, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 4'h8, 32'h12345678, 4'h5, 32'h0,        1'b1, 1'b0};
        vecs[12] = '{1'b0, 4'h8, 32'h0,        4'hF, 32'h00340078, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 4'h4, 32'h00000101, 4'hF, 32'h0,        1'b1, 1'b1};
        vecs[14] = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h00010101, 1'b1, 1'b1};

        // Reset state
        #1 wb_rst_n = 1'b0;
        #1;
        check("reset_pins", {24'd0, sr_clk, sr_do, sr_aux_do, sr_oe},  32'h0);
        check("reset_gpio_ack", {29'd0, gpio_o, gpio_oe, ack}, 32'h0);
        check("reset_dat_o", dat_o, 32'h0);
        repeat (3) @(posedge wb_clk);
        #2 wb_rst_n = 1'b1;

        // Register table
        gpio_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            int t;
            wb_xfer(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, rd, t);
            if (!vecs[i].w) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_gpio", i), {30'd0, gpio_o[0], gpio_oe[0]},
                  {30'd0, vecs[i].exp_go, vecs[i].exp_oe});
        end

        // LSB-first loopback on module 1
        wb_write(4'h0, 32'h00070011);
        wb_write(4'h8, 32'h00000001);
        e0 = clk0_edges; e1 = clk1_edges;
        run_seq(32'hA5, 32'h1, b);
        check("lsb_busy", b, 33);
        check("lsb_tck1_edges", clk1_edges - e1, 8);
        check("lsb_tck0_edges", clk0_edges - e0, 0);
        check("lsb_tms_bits", {24'd0, hist1_tms[7:0]}, 32'h80);
        check("lsb_tdi_bits", {24'd0, hist1_tdi[7:0]}, 32'hA5);
        check("lsb_idle_pins", {30'd0, sr_clk[1], sr_oe[1]}, 32'h1);
        wb_read(4'hC, rd);
        check("lsb_capture", rd, 32'h000000A5);

        // Stalled TDI write chains a second sequence
        e1 = clk1_edges;
        begin
            logic [31:0] r2;
            int t0, t1;
            wb_xfer(1'b1, 4'hC, 32'h5A, 4'hF, r2, t0);
            wb_xfer(1'b1, 4'hC, 32'h03, 4'hF, r2, t1);
            check("stall_busy", t1 - t0 - 1, 33);
        end
        wait_idle();
        wb_read(4'hC, rd);
        check("stall_capture", rd, 32'h00000003);
        check("stall_tck1_edges", clk1_edges - e1, 16);
        check("stall_tdi_bits", {24'd0, hist1_tdi[7:0]}, 32'hC0);

        // MSB-first, 32 bits, div=3 on module 0
        wb_write(4'h0, 32'h001F0330);
        e0 = clk0_edges; e1 = clk1_edges;
        run_seq(32'h80000001, 32'h0, b);
        check("msb_busy", b, 516);
        check("msb_tck0_edges", clk0_edges - e0, 32);
        check("msb_tck1_edges", clk1_edges - e1, 0);
        check("msb_tdi_bits", hist0_tdi, 32'h80000001);
        wb_read(4'hC, rd);
        check("msb_capture", rd, 32'h80000001);

        // Out-of-range module select: timing only, nothing driven
        wb_write(4'h0, 32'h00030013);
        e0 = clk0_edges; e1 = clk1_edges;
        run_seq(32'h0000000F, 32'h0, b);
        check("nomod_busy", b, 17);
        check("nomod_edges", (clk0_edges - e0) + (clk1_edges - e1), 0);
        check("nomod_oe", {30'd0, sr_oe}, 32'h0);
        wb_read(4'hC, rd);
        check("nomod_capture", rd, 32'h0);

        // Asynchronous reset in the middle of SHIFT
        wb_write(4'h0, 32'h00070311);
        wb_write(4'h8, 32'h0);
        wb_write(4'hC, 32'hFF);
        repeat (20) @(posedge wb_clk);
        #2;
        check("midrst_pre", {30'd0, sr_oe[1], sr_do[1]}, 32'h3);
        wb_rst_n = 1'b0;
        #1;
        check("midrst_pins", {24'd0, sr_clk, sr_do, sr_aux_do, sr_oe}, 32'h0);
        check("midrst_gpio", {30'd0, gpio_o, gpio_oe}, 32'h0);
        #20 wb_rst_n = 1'b1;
        wb_read(4'h0, rd);
        check("midrst_ctrl", rd, 32'h0);
        wb_write(4'h0, 32'h00070011);
        wb_write(4'h8, 32'h0);
        run_seq(32'h3C, 32'h0, b);
        check("midrst_busy", b, 33);
        wb_read(4'hC, rd);
        check("midrst_capture", rd, 32'h0000003C);

        check("ack_back_to_back", ack_double, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
